buffer_slot_requester: RTL and testbench
========================================

# buffer_slot_requester

Hardware initiator for the buffer arbiter's get/put req/ack slot protocol. Obtains a buffer slot index through a get handshake and holds it for local user logic. When the user releases the slot, returns the index through a put handshake. One instance sits on the in side and one on the out side of each arbiter client, in place of bench-driven stimulus.

## Interface
Parameters:
- C_DATA_WIDTH, 32, width of slot index/info word
- C_ACK_TIMEOUT, 1024, cycles allowed per handshake phase (used only with BUF_REQ_TIMEOUT_EN)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start_i  in  1  request a slot; sampled only in IDLE
- busy_o  out  1  high in every state except IDLE
- get_req_o  out  1  get request to arbiter
- get_ack_i  in  1  get acknowledge from arbiter
- get_data_i  in  C_DATA_WIDTH  slot index, valid while get_ack_i high
- get_err_i  in  1  arbiter overflow/underflow flag, valid with get_ack_i
- put_req_o  out  1  put request to arbiter
- put_ack_i  in  1  put acknowledge from arbiter
- put_data_o  out  C_DATA_WIDTH  slot index being returned
- slot_vld_o  out  1  slot owned; slot_data_o valid
- slot_data_o  out  C_DATA_WIDTH  owned slot index
- release_i  in  1  user finished with slot; sampled only in HOLD
- done_o  out  1  one-cycle pulse when put handshake completes
- err_o  out  1  sticky: get completed with get_err_i=1
- timeout_o  out  1  sticky: handshake phase exceeded C_ACK_TIMEOUT
- clr_err_i  in  1  clears err_o and timeout_o

## Operation
- States: IDLE, GET_REQ, GET_REL, HOLD, PUT_REQ, PUT_REL. All outputs registered.
- Reset value of every output is 0. State returns to IDLE. slot_data_o and put_data_o are 0.
- IDLE: start_i=1 -> get_req_o<=1, go to GET_REQ.
- GET_REQ: get_ack_i=1 -> get_req_o<=0, slot_data_o<=get_data_i, latch get_err_i, go to GET_REL.
- GET_REL: wait for get_ack_i=0 (four-phase return-to-zero).
  - Latched error: err_o<=1, go to IDLE, and no slot is owned.
  - Otherwise: slot_vld_o<=1, go to HOLD.
- HOLD: release_i=1 -> slot_vld_o<=0, put_req_o<=1, put_data_o<=slot_data_o, go to PUT_REQ.
- PUT_REQ: put_ack_i=1 -> put_req_o<=0, go to PUT_REL.
- PUT_REL: put_ack_i=0 -> done_o<=1 for one cycle, go to IDLE.
- Acks arriving outside their wait state are ignored. A req is never re-asserted until the matching ack has been seen low.
- clr_err_i has priority over a same-cycle error set: both flags clear that cycle, and the new event is dropped.
- Reset mid-handshake drops req immediately (async). The arbiter is responsible for recovering a lost slot.

## Timing
- start_i high at edge N -> get_req_o high after edge N.
- get_ack_i first sampled high at edge M -> get_req_o low and slot_data_o valid after edge M.
- get_ack_i sampled low at edge K in GET_REL -> slot_vld_o high after edge K.
- release_i at edge R -> put_req_o high after edge R.
- Minimum get-to-own latency is 3 cycles, given an ack held for 1 cycle.
- Minimum release-to-done latency is 3 cycles.
- start_i held high continuously produces back-to-back slot acquisitions, separated by 1 IDLE cycle.

## Configuration
- BUF_REQ_TIMEOUT_EN defined:
  - A counter of width clog2(C_ACK_TIMEOUT+1) counts cycles in GET_REQ, GET_REL, PUT_REQ and PUT_REL. It resets to 0 on every state change.
  - When the count reaches C_ACK_TIMEOUT, the active req drops, timeout_o<=1 and the block goes to IDLE. slot_vld_o is 0 and no done_o pulse is issued.
- BUF_REQ_TIMEOUT_EN undefined:
  - No counter is built and handshakes wait indefinitely.
  - timeout_o is tied to 0, and C_ACK_TIMEOUT is unused.

## Test plan
- Basic cycle: pulse start_i, ack after 2 cycles with get_data_i=0x5, drop ack, then release_i after 4 cycles and ack the put. Required: slot_data_o=0x5, put_data_o=0x5, exactly one done_o pulse, all outputs return to 0.
- Held ack: keep get_ack_i high for 6 cycles. Required: get_req_o drops after the first ack edge, and slot_vld_o rises only on the cycle after get_ack_i falls.
- Error: get_err_i=1 with get_ack_i. Required: err_o=1, slot_vld_o stays 0, put_req_o never asserts, and the block returns to IDLE. Then clr_err_i. Required: err_o=0.
- Back-to-back: hold start_i high with indices 0..15 returned in order. Required: 16 HOLD entries with matching slot_data_o and 16 done_o pulses.
- Reset during PUT_REQ: assert rst asynchronously. Required: put_req_o=0 and busy_o=0 immediately, with no done_o pulse.
- With BUF_REQ_TIMEOUT_EN and C_ACK_TIMEOUT=8: never ack. Required: get_req_o drops 8 cycles after rising, timeout_o=1, busy_o=0.

Source files
------------

// File: rtl/buffer_slot_requester.sv
// buffer_slot_requester
// Four-phase req/ack initiator for the buffer arbiter's get/put slot protocol.
// It obtains a slot index with a get handshake and holds it for local user
// logic. When the user releases the slot, it hands the index back with a put
// handshake.
// Optional feature macro: BUF_REQ_TIMEOUT_EN. When defined, every handshake
// phase is bounded by C_ACK_TIMEOUT cycles. When undefined, handshakes wait
// indefinitely and timeout_o stays 0.
module buffer_slot_requester #(
   parameter int C_DATA_WIDTH  = 32,
   parameter int C_ACK_TIMEOUT = 1024
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start_i,
   output logic                    busy_o,
   output logic                    get_req_o,
   input  logic                    get_ack_i,
   input  logic [C_DATA_WIDTH-1:0] get_data_i,
   input  logic                    get_err_i,
   output logic                    put_req_o,
   input  logic                    put_ack_i,
   output logic [C_DATA_WIDTH-1:0] put_data_o,
   output logic                    slot_vld_o,
   output logic [C_DATA_WIDTH-1:0] slot_data_o,
   input  logic                    release_i,
   output logic                    done_o,
   output logic                    err_o,
   output logic                    timeout_o,
   input  logic                    clr_err_i
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] GET_REQ = 3'd1;
   localparam logic [2:0] GET_REL = 3'd2;
   localparam logic [2:0] HOLD    = 3'd3;
   localparam logic [2:0] PUT_REQ = 3'd4;
   localparam logic [2:0] PUT_REL = 3'd5;

   logic [2:0] state;
   logic       err_latched;
   logic       advance;
   logic       expire;
   logic       err_set;

   // Condition under which the current state moves on to its successor
   always_comb begin
      advance = 1'b0;
      case (state)
         IDLE:    advance = start_i;
         GET_REQ: advance = get_ack_i;
         GET_REL: advance = !get_ack_i;
         HOLD:    advance = release_i;
         PUT_REQ: advance = put_ack_i;
         PUT_REL: advance = !put_ack_i;
         default: advance = 1'b0;
      endcase
   end

   assign err_set = (state == GET_REL) && !get_ack_i && err_latched;

`ifdef BUF_REQ_TIMEOUT_EN
   localparam int CNT_W = $clog2(C_ACK_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_ACK_TIMEOUT - 1);

   logic [CNT_W-1:0] wait_cnt;
   logic             in_wait;

   assign in_wait = (state == GET_REQ) || (state == GET_REL) ||
                    (state == PUT_REQ) || (state == PUT_REL);

   // Expiry fires on the edge at which the phase has lasted C_ACK_TIMEOUT cycles; a same-edge ack still wins
   assign expire = in_wait && !advance && (wait_cnt == CNT_LAST);

   // Per-phase cycle counter, cleared on every state change and outside the handshake phases
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (!in_wait || advance || expire) begin
         wait_cnt <= '0;
      end else begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // Sticky timeout flag; a same-cycle clear wins and the new event is dropped
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timeout_o <= 1'b0;
      end else if (clr_err_i) begin
         timeout_o <= 1'b0;
      end else if (expire) begin
         timeout_o <= 1'b1;
      end
   end
`else
   assign expire    = 1'b0;
   assign timeout_o = 1'b0;
`endif

   // Sticky arbiter error flag; a same-cycle clear wins and the new event is dropped
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_o <= 1'b0;
      end else if (clr_err_i) begin
         err_o <= 1'b0;
      end else if (err_set) begin
         err_o <= 1'b1;
      end
   end

   // Handshake sequencer: every output is a register updated on the transition into the next state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         busy_o      <= 1'b0;
         get_req_o   <= 1'b0;
         put_req_o   <= 1'b0;
         put_data_o  <= '0;
         slot_vld_o  <= 1'b0;
         slot_data_o <= '0;
         done_o      <= 1'b0;
         err_latched <= 1'b0;
      end else begin
         done_o <= 1'b0;
         if (expire) begin
            state      <= IDLE;
            busy_o     <= 1'b0;
            get_req_o  <= 1'b0;
            put_req_o  <= 1'b0;
            slot_vld_o <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start_i) begin
                     get_req_o <= 1'b1;
                     busy_o    <= 1'b1;
                     state     <= GET_REQ;
                  end
               end
               GET_REQ: begin
                  if (get_ack_i) begin
                     get_req_o   <= 1'b0;
                     slot_data_o <= get_data_i;
                     err_latched <= get_err_i;
                     state       <= GET_REL;
                  end
               end
               GET_REL: begin
                  if (!get_ack_i) begin
                     if (err_latched) begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                     end else begin
                        slot_vld_o <= 1'b1;
                        state      <= HOLD;
                     end
                  end
               end
               HOLD: begin
                  if (release_i) begin
                     slot_vld_o <= 1'b0;
                     put_req_o  <= 1'b1;
                     put_data_o <= slot_data_o;
                     state      <= PUT_REQ;
                  end
               end
               PUT_REQ: begin
                  if (put_ack_i) begin
                     put_req_o <= 1'b0;
                     state     <= PUT_REL;
                  end
               end
               PUT_REL: begin
                  if (!put_ack_i) begin
                     done_o <= 1'b1;
                     busy_o <= 1'b0;
                     state  <= IDLE;
                  end
               end
               default: begin
                  busy_o    <= 1'b0;
                  get_req_o <= 1'b0;
                  put_req_o <= 1'b0;
                  state     <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_buffer_slot_requester.sv
// Testbench for buffer_slot_requester.
// Directed stimulus plays the arbiter side. Expected slot ownership, put
// completion and error events are queued when each stimulus is issued. A
// separate monitor pops and compares them whenever the DUT presents one.
// The timeout scenario runs only when BUF_REQ_TIMEOUT_EN is defined.
module tb_buffer_slot_requester;

   localparam int DW = 32;
   localparam logic [1:0] EV_OWN  = 2'd0;
   localparam logic [1:0] EV_DONE = 2'd1;
   localparam logic [1:0] EV_ERR  = 2'd2;

   typedef struct {
      logic [1:0]    kind;
      logic [DW-1:0] data;
   } exp_t;

   exp_t exp_q[$];

   int pass_cnt  = 0;
   int total_cnt = 0;
   int own_cnt   = 0;
   int done_cnt  = 0;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          busy_o;
   logic          get_req_o;
   logic          get_ack = 1'b0;
   logic [DW-1:0] get_data = '0;
   logic          get_err = 1'b0;
   logic          put_req_o;
   logic          put_ack = 1'b0;
   logic [DW-1:0] put_data_o;
   logic          slot_vld_o;
   logic [DW-1:0] slot_data_o;
   logic          release_slot = 1'b0;
   logic          done_o;
   logic          err_o;
   logic          timeout_o;
   logic          clr_err = 1'b0;

   logic          prev_vld = 1'b0;
   logic          prev_err = 1'b0;

   always #5 clk = ~clk;

   buffer_slot_requester #(
      .C_DATA_WIDTH (DW),
      .C_ACK_TIMEOUT(8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start),
      .busy_o     (busy_o),
      .get_req_o  (get_req_o),
      .get_ack_i  (get_ack),
      .get_data_i (get_data),
      .get_err_i  (get_err),
      .put_req_o  (put_req_o),
      .put_ack_i  (put_ack),
      .put_data_o (put_data_o),
      .slot_vld_o (slot_vld_o),
      .slot_data_o(slot_data_o),
      .release_i  (release_slot),
      .done_o     (done_o),
      .err_o      (err_o),
      .timeout_o  (timeout_o),
      .clr_err_i  (clr_err)
   );

   // Single-bit comparison with pass/total bookkeeping
   task automatic check_bit(input string name, input logic actual, input logic expected);
      total_cnt++;
      if (actual === expected) pass_cnt++;
      else $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
   endtask

   // Word comparison with pass/total bookkeeping
   task automatic check_word(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
      total_cnt++;
      if (actual === expected) pass_cnt++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_expect(input logic [1:0] kind, input logic [DW-1:0] data);
      exp_t item;
      item.kind = kind;
      item.data = data;
      exp_q.push_back(item);
   endtask

   // Scoreboard pop: compare event kind and, where meaningful, the carried index
   task automatic pop_expect(input string name, input logic [1:0] kind, input logic [DW-1:0] data);
      exp_t item;
      if (exp_q.size() == 0) begin
         check_bit({name, "_unexpected"}, 1'b1, 1'b0);
      end else begin
         item = exp_q.pop_front();
         check_word({name, "_kind"}, DW'(kind), DW'(item.kind));
         if (kind != EV_ERR) check_word({name, "_data"}, data, item.data);
      end
   endtask

   // Monitor: reacts to ownership, completion and error events presented by the DUT
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (slot_vld_o && !prev_vld) begin
               own_cnt++;
               pop_expect("own", EV_OWN, slot_data_o);
            end
            if (done_o) begin
               done_cnt++;
               pop_expect("done", EV_DONE, put_data_o);
            end
            if (err_o && !prev_err) pop_expect("err", EV_ERR, '0);
         end
         prev_vld = slot_vld_o;
         prev_err = err_o;
      end
   end

   // Get handshake as the arbiter: ack after ack_delay cycles, hold it ack_hold cycles
   task automatic apply_stimulus(input logic [DW-1:0] data, input logic err,
                                 input int ack_delay, input int ack_hold, input logic keep_start);
      start = 1'b1;
      tick();
      start = keep_start;
      check_bit("get_req_rise", get_req_o, 1'b1);
      repeat (ack_delay) tick();
      get_ack  = 1'b1;
      get_data = data;
      get_err  = err;
      push_expect(err ? EV_ERR : EV_OWN, data);
      tick();
      check_bit("get_req_drop", get_req_o, 1'b0);
      repeat (ack_hold - 1) tick();
      check_bit("get_req_stays_low", get_req_o, 1'b0);
      check_bit("vld_while_ack", slot_vld_o, 1'b0);
      get_ack  = 1'b0;
      get_err  = 1'b0;
      get_data = '0;
      tick();
      if (!err) begin
         check_bit("vld_after_ack_low", slot_vld_o, 1'b1);
         check_word("slot_data", slot_data_o, data);
      end else begin
         check_bit("err_set", err_o, 1'b1);
         check_bit("err_no_vld", slot_vld_o, 1'b0);
         check_bit("err_idle", busy_o, 1'b0);
      end
   endtask

   // Put handshake: release after rel_delay cycles, then ack the put for one cycle
   task automatic return_slot(input logic [DW-1:0] data, input int rel_delay);
      repeat (rel_delay) tick();
      release_slot = 1'b1;
      push_expect(EV_DONE, data);
      tick();
      release_slot = 1'b0;
      check_bit("put_req_rise", put_req_o, 1'b1);
      check_word("put_data", put_data_o, data);
      check_bit("vld_drop", slot_vld_o, 1'b0);
      put_ack = 1'b1;
      tick();
      check_bit("put_req_drop", put_req_o, 1'b0);
      put_ack = 1'b0;
      tick();
      check_bit("done_pulse", done_o, 1'b1);
      check_bit("busy_after_done", busy_o, 1'b0);
   endtask

   initial begin
      int own_base;
      int done_base;
      int cycles;

      repeat (3) tick();
      check_bit("rst_busy", busy_o, 1'b0);
      check_bit("rst_get_req", get_req_o, 1'b0);
      check_bit("rst_put_req", put_req_o, 1'b0);
      check_bit("rst_vld", slot_vld_o, 1'b0);
      check_word("rst_slot_data", slot_data_o, '0);
      check_word("rst_put_data", put_data_o, '0);
      check_bit("rst_done", done_o, 1'b0);
      check_bit("rst_err", err_o, 1'b0);
      check_bit("rst_timeout", timeout_o, 1'b0);
      rst = 1'b0;
      tick();

      $display("[TB] stray acks in IDLE");
      get_ack = 1'b1;
      put_ack = 1'b1;
      tick();
      get_ack = 1'b0;
      put_ack = 1'b0;
      check_bit("stray_busy", busy_o, 1'b0);
      check_bit("stray_get_req", get_req_o, 1'b0);
      check_bit("stray_put_req", put_req_o, 1'b0);

      $display("[TB] basic cycle");
      done_base = done_cnt;
      apply_stimulus(32'h5, 1'b0, 2, 1, 1'b0);
      return_slot(32'h5, 4);
      tick();
      check_bit("basic_done_low", done_o, 1'b0);
      check_bit("basic_busy_low", busy_o, 1'b0);
      check_bit("basic_vld_low", slot_vld_o, 1'b0);
      check_bit("basic_reqs_low", get_req_o | put_req_o, 1'b0);
      check_word("basic_one_done", DW'(done_cnt - done_base), 32'd1);

      $display("[TB] held get ack");
      apply_stimulus(32'hA, 1'b0, 0, 6, 1'b0);
      return_slot(32'hA, 1);

      $display("[TB] arbiter error");
      apply_stimulus(32'h3, 1'b1, 1, 1, 1'b0);
      repeat (3) tick();
      check_bit("err_no_put_req", put_req_o, 1'b0);
      check_bit("err_still_idle", busy_o, 1'b0);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      check_bit("err_cleared", err_o, 1'b0);

      $display("[TB] back-to-back acquisitions");
      own_base  = own_cnt;
      done_base = done_cnt;
      for (int i = 0; i < 16; i++) begin
         apply_stimulus(DW'(i), 1'b0, 0, 1, 1'b1);
         return_slot(DW'(i), 0);
      end
      start = 1'b0;
      tick();
      check_word("b2b_owns", DW'(own_cnt - own_base), 32'd16);
      check_word("b2b_dones", DW'(done_cnt - done_base), 32'd16);

      $display("[TB] reset during PUT_REQ");
      apply_stimulus(32'h7, 1'b0, 1, 1, 1'b0);
      release_slot = 1'b1;
      tick();
      release_slot = 1'b0;
      check_bit("pre_rst_put_req", put_req_o, 1'b1);
      done_base = done_cnt;
      #2;
      rst = 1'b1;
      #1;
      check_bit("async_put_req", put_req_o, 1'b0);
      check_bit("async_busy", busy_o, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      repeat (3) tick();
      check_word("rst_no_done", DW'(done_cnt - done_base), 32'd0);

`ifdef BUF_REQ_TIMEOUT_EN
      $display("[TB] get ack timeout");
      done_base = done_cnt;
      start = 1'b1;
      tick();
      start = 1'b0;
      check_bit("to_get_req_rise", get_req_o, 1'b1);
      cycles = 0;
      while (get_req_o && cycles < 20) begin
         tick();
         cycles++;
      end
      check_word("to_cycles", DW'(cycles), 32'd8);
      check_bit("to_flag", timeout_o, 1'b1);
      check_bit("to_busy", busy_o, 1'b0);
      check_bit("to_vld", slot_vld_o, 1'b0);
      tick();
      check_word("to_no_done", DW'(done_cnt - done_base), 32'd0);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      check_bit("to_cleared", timeout_o, 1'b0);
`else
      $display("[TB] unbounded get wait");
      start = 1'b1;
      tick();
      start = 1'b0;
      cycles = 0;
      while (get_req_o && cycles < 12) begin
         tick();
         cycles++;
      end
      check_bit("wait_get_req_held", get_req_o, 1'b1);
      check_bit("wait_no_timeout", timeout_o, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
`endif

      check_word("sb_empty", DW'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   // Watchdog so the run always terminates
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running, required finish");
      total_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
